// File: rtl/seg_scan_ctrl.sv
// Prescaled multiplexed seven-segment scanner with frame-synchronous shadow loading and PWM dimming.
// Optional leading-zero suppression is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 100000,
  parameter int DUTY_BITS  = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [DUTY_BITS-1:0]          brightness,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    cathode,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_select,
  output logic                          frame_tick,
  output logic                          load_pending
);

  localparam int SW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0]         PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]         SEL_MAX = SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [PW-1:0] pre_cnt, pre_nxt;
  logic [SW-1:0] sel_nxt;
  logic          slot_end, commit;

  logic [NUM_DIGITS-1:0][3:0] pend_dig, act_dig;
  logic [NUM_DIGITS-1:0]      pend_en, pend_dp, act_en, act_dp, act_sup, lz_mask;

  always_comb begin
    slot_end = (pre_cnt == PRE_MAX);
    pre_nxt  = slot_end ? '0 : pre_cnt + 1'b1;
    sel_nxt  = digit_select;
    if (slot_end) sel_nxt = (digit_select == SEL_MAX) ? '0 : digit_select + 1'b1;
    // a load landing on the frame_tick cycle wins over commit and waits a frame
    commit   = frame_tick && load_pending && !load;
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    lz_mask = '0;
    seen    = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (!seen && pend_dig[i] == 4'h0) lz_mask[i] = 1'b1;
      else                              seen       = 1'b1;
    end
  end
`else
  assign lz_mask = '0;
`endif

  logic pwm_on, gate, lit, dp_only;
  always_comb begin
    pwm_on  = (pre_cnt[DUTY_BITS-1:0] < brightness) || (&brightness);
    // slot's first cycle stays dark so the previous digit never ghosts into this one
    gate    = (pre_cnt != '0) && pwm_on;
    lit     = gate && act_en[digit_select];
    dp_only = gate && act_sup[digit_select];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pre_cnt      <= '0;
      digit_select <= '0;
      frame_tick   <= 1'b0;
      load_pending <= 1'b0;
      pend_dig     <= '0;
      pend_en      <= '0;
      pend_dp      <= '0;
      act_dig      <= '0;
      act_en       <= '0;
      act_dp       <= '0;
      act_sup      <= '0;
      anode        <= '1;
      cathode      <= 7'h7F;
      dp_n         <= 1'b1;
    end else begin
      pre_cnt      <= pre_nxt;
      digit_select <= sel_nxt;
      frame_tick   <= (pre_nxt == PRE_MAX) && (sel_nxt == SEL_MAX);

      if (load) begin
        pend_dig     <= digits_in;
        pend_en      <= digit_en;
        pend_dp      <= dp_in;
        load_pending <= 1'b1;
      end else if (commit) begin
        load_pending <= 1'b0;
      end

      if (commit) begin
        act_dig <= pend_dig;
        act_en  <= pend_en & ~lz_mask;
        act_dp  <= pend_dp;
        act_sup <= lz_mask;
      end

      anode   <= lit ? ~(ONE_HOT0 << digit_select) : '1;
      cathode <= lit ? hex7(act_dig[digit_select]) : 7'h7F;
      dp_n    <= !((lit || dp_only) && act_dp[digit_select]);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, PRESCALE=4, DUTY_BITS=2, plus a PRESCALE=8 instance for PWM.
module tb_seg_scan_ctrl;

  logic        aclk = 1'b0, aresetn = 1'b1, load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  digit_en = '0, dp_in = '0;
  logic [1:0]  brightness = 2'd3;

  logic [3:0] anode, anode2;
  logic [6:0] cathode, cathode2;
  logic       dp_n, dp_n2, frame_tick, frame_tick2, load_pending, load_pending2;
  logic [1:0] digit_select, digit_select2;

  int npass = 0, ntot = 0;

  always #5 aclk = ~aclk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .DUTY_BITS(2)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .load(load), .digits_in(digits_in),
    .digit_en(digit_en), .dp_in(dp_in), .brightness(brightness),
    .anode(anode), .cathode(cathode), .dp_n(dp_n), .digit_select(digit_select),
    .frame_tick(frame_tick), .load_pending(load_pending));

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .DUTY_BITS(2)) u_pwm (
    .aclk(aclk), .aresetn(aresetn), .load(load), .digits_in(digits_in),
    .digit_en(digit_en), .dp_in(dp_in), .brightness(brightness),
    .anode(anode2), .cathode(cathode2), .dp_n(dp_n2), .digit_select(digit_select2),
    .frame_tick(frame_tick2), .load_pending(load_pending2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) begin npass++; end
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic wait_ft();
    int k = 0;
    do begin tick(); k++; end while (!frame_tick && k < 64);
    chk("ft_reached", frame_tick, 1'b1);
  endtask

  task automatic wait_ft2();
    int k = 0;
    do begin tick(); k++; end while (!frame_tick2 && k < 128);
    chk("ft2_reached", frame_tick2, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp);
    digits_in = d; digit_en = en; dp_in = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // reset state
    #2 aresetn = 1'b0;
    #1;
    chk("rst_anode", anode, 4'hF);
    chk("rst_cathode", cathode, 7'h7F);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_sel", digit_select, 2'd0);
    chk("rst_lp", load_pending, 1'b0);
    chk("rst_ft", frame_tick, 1'b0);
    tick(2);
    chk("rst_hold_anode", anode, 4'hF);
    aresetn = 1'b1;

    // first load, committed at the first frame_tick
    do_load(16'h3210, 4'hF, 4'b0010);
    chk("lp_set", load_pending, 1'b1);
    wait_ft();
    chk("ft_sel", digit_select, 2'd3);
    chk("lp_at_ft", load_pending, 1'b1);
    tick();
    chk("lp_clr", load_pending, 1'b0);
    chk("sel_wrap", digit_select, 2'd0);
    tick(2);
    chk("s0_anode", anode, 4'b1110);
    chk("s0_cath", cathode, 7'h40);
    chk("s0_dp", dp_n, 1'b1);
    tick(3);
    chk("ghost_anode", anode, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s1_anode", anode, 4'b1101);
      chk("s1_cath", cathode, 7'h79);
      chk("s1_dp", dp_n, 1'b0);
    end
    tick(2);
    chk("s2_anode", anode, 4'b1011);
    chk("s2_cath", cathode, 7'h24);

    // tear-free: FFFF then 8888 before commit
    do_load(16'hFFFF, 4'hF, 4'h0);
    chk("lp_mid", load_pending, 1'b1);
    tick(3);
    chk("s3_old_anode", anode, 4'b0111);
    chk("s3_old_cath", cathode, 7'h30);
    do_load(16'h8888, 4'hF, 4'h0);
    chk("ft_frame2", frame_tick, 1'b1);
    chk("lp_frame2", load_pending, 1'b1);
    tick(3);
    chk("new_s0_anode", anode, 4'b1110);
    chk("new_s0_cath", cathode, 7'h00);
    tick(4);
    chk("new_s1_cath", cathode, 7'h00);

    // load coincident with frame_tick: deferred one frame
    wait_ft();
    do_load(16'h0070, 4'hF, 4'b1000);
    chk("coinc_lp", load_pending, 1'b1);
    tick(2);
    chk("coinc_old_cath", cathode, 7'h00);
    wait_ft();
    chk("coinc_lp_ft", load_pending, 1'b1);
    tick();
    chk("coinc_lp_clr", load_pending, 1'b0);
    tick(2);
    chk("lz_d0_anode", anode, 4'b1110);
    chk("lz_d0_cath", cathode, 7'h40);
    tick(4);
    chk("lz_d1_anode", anode, 4'b1101);
    chk("lz_d1_cath", cathode, 7'h78);
    tick(4);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("lz_d2_anode", anode, 4'hF);
    chk("lz_d2_cath", cathode, 7'h7F);
    chk("lz_d2_dp", dp_n, 1'b1);
    tick(4);
    chk("lz_d3_anode", anode, 4'hF);
    chk("lz_d3_cath", cathode, 7'h7F);
    chk("lz_d3_dp", dp_n, 1'b0);
`else
    chk("lz_d2_anode", anode, 4'b1011);
    chk("lz_d2_cath", cathode, 7'h40);
    tick(4);
    chk("lz_d3_anode", anode, 4'b0111);
    chk("lz_d3_cath", cathode, 7'h40);
    chk("lz_d3_dp", dp_n, 1'b0);
`endif

    // brightness 0 keeps the display dark for a whole frame
    brightness = 2'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("dark_anode", anode, 4'hF);
    end
    brightness = 2'd3;

    // asynchronous reset mid-slot discards pending data
    wait_ft();
    tick(7);
    do_load(16'h1111, 4'hF, 4'h0);
    chk("pre_rst_anode", anode, 4'b1101);
    chk("pre_rst_lp", load_pending, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_anode", anode, 4'hF);
    chk("arst_cath", cathode, 7'h7F);
    chk("arst_dp", dp_n, 1'b1);
    chk("arst_sel", digit_select, 2'd0);
    chk("arst_lp", load_pending, 1'b0);
    tick(2);
    aresetn = 1'b1;
    tick(3);
    chk("restart_sel0", digit_select, 2'd0);
    tick();
    chk("restart_sel1", digit_select, 2'd1);
    chk("restart_lp", load_pending, 1'b0);
    chk("restart_anode", anode, 4'hF);

    // PWM on the PRESCALE=8 instance: lit only at pre_cnt 1,4,5
    brightness = 2'd2;
    do_load(16'h0005, 4'h1, 4'h0);
    wait_ft2();
    tick();
    for (int p = 0; p < 8; p++) begin
      tick();
      chk("pwm_anode", anode2, (p == 1 || p == 4 || p == 5) ? 4'b1110 : 4'hF);
      chk("pwm_cath", cathode2, (p == 1 || p == 4 || p == 5) ? 7'h12 : 7'h7F);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
